// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button conditioning path: per-lane debounce
// FSM encoding and the board's button lane assignments.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        StIdleLo = 2'd0,
        StChkHi  = 2'd1,
        StIdleHi = 2'd2,
        StChkLo  = 2'd3
    } db_state_e;

    localparam int unsigned NumBtn   = 4;
    localparam int unsigned BtnUp    = 0;
    localparam int unsigned BtnDown  = 1;
    localparam int unsigned BtnLeft  = 2;
    localparam int unsigned BtnRight = 3;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bus between the board pins (master) and the debouncer (slave).
// Bit i of every vector belongs to button lane i.
interface btn_debounce_if
    import btn_debounce_pkg::*;
#(
    parameter int unsigned N_BTN = NumBtn
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_debounce_sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous pin; resets to 0.
module btn_debounce_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: per-lane synchroniser, counter-based debounce FSM and
// registered single-cycle press/release pulses. Lanes share no state.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic           clk,
    input  logic           reset,
    btn_debounce_if.slave  btn_io
);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    if ((DEBOUNCE_CYCLES < 1) ||
        (64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_param
        $error("btn_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    logic [N_BTN-1:0] sync_w;
    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] press_w;
    logic [N_BTN-1:0] release_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        db_state_e        state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             press_q;
        logic             release_q;

        btn_debounce_sync_2ff u_sync (
            .clk   (clk),
            .reset (reset),
            .d_i   (btn_io.btn_raw[i]),
            .q_o   (sync_w[i])
        );

        // cnt_q counts edges on which sync_w has differed from level_q; it is
        // cleared on every bounce or acceptance, so it never exceeds CntLast.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q   <= StIdleLo;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                unique case (state_q)
                    StIdleLo: begin
                        if (sync_w[i]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q <= StIdleHi;
                                level_q <= 1'b1;
                                press_q <= 1'b1;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= StChkHi;
                                cnt_q   <= CntOne;
                            end
                        end
                    end
                    StChkHi: begin
                        if (!sync_w[i]) begin
                            state_q <= StIdleLo;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StIdleHi;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                    StIdleHi: begin
                        if (!sync_w[i]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q   <= StIdleLo;
                                level_q   <= 1'b0;
                                release_q <= 1'b1;
                                cnt_q     <= '0;
                            end else begin
                                state_q <= StChkLo;
                                cnt_q   <= CntOne;
                            end
                        end
                    end
                    StChkLo: begin
                        if (sync_w[i]) begin
                            state_q <= StIdleHi;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q   <= StIdleLo;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                endcase
            end
        end

        assign level_w[i]   = level_q;
        assign press_w[i]   = press_q;
        assign release_w[i] = release_q;
    end

    assign btn_io.btn_level   = level_w;
    assign btn_io.btn_press   = press_w;
    assign btn_io.btn_release = release_w;
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: a 4-cycle and a 1-cycle debounce build driven in
// parallel, checked against a behavioural model plus directed sequences.
module tb_btn_debounce;
    localparam int unsigned NB = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned DC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] raw = '0;

    btn_debounce_if #(.N_BTN(NB)) bus0 ();
    btn_debounce_if #(.N_BTN(NB)) bus1 ();

    assign bus0.btn_raw = raw;
    assign bus1.btn_raw = raw;

    btn_debounce #(.N_BTN(NB), .CNT_W(CW), .DEBOUNCE_CYCLES(DC)) u_dut0 (
        .clk    (clk),
        .reset  (rst),
        .btn_io (bus0)
    );

    btn_debounce #(.N_BTN(NB), .CNT_W(CW), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk    (clk),
        .reset  (rst),
        .btn_io (bus1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: raw seen by the FSM two edges late; a lane flips once
    // the seen value has disagreed with the level for D consecutive edges.
    int dcyc[2] = '{DC, 1};
    bit m_s1[2][NB];
    bit m_s2[2][NB];
    bit m_level[2][NB];
    bit m_press[2][NB];
    bit m_rel[2][NB];
    int m_run[2][NB];
    int pcnt[NB];
    int rcnt[NB];

    typedef struct {
        logic [NB-1:0] raw;
        int            hold;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
    } row_t;

    row_t rows[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_out(input int d);
        if (d == 0) return 32'({bus0.btn_level, bus0.btn_press, bus0.btn_release});
        return 32'({bus1.btn_level, bus1.btn_press, bus1.btn_release});
    endfunction

    function automatic logic [31:0] model_out(input int d);
        logic [NB-1:0] l, p, r;
        for (int i = 0; i < NB; i++) begin
            l[i] = m_level[d][i];
            p[i] = m_press[d][i];
            r[i] = m_rel[d][i];
        end
        return 32'({l, p, r});
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NB; i++) begin
                m_s1[d][i] = 1'b0; m_s2[d][i] = 1'b0; m_level[d][i] = 1'b0;
                m_press[d][i] = 1'b0; m_rel[d][i] = 1'b0; m_run[d][i] = 0;
            end
        end
    endtask

    task automatic model_step();
        bit seen;
        if (rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NB; i++) begin
                seen = m_s2[d][i];
                m_s2[d][i] = m_s1[d][i];
                m_s1[d][i] = raw[i];
                m_press[d][i] = 1'b0;
                m_rel[d][i] = 1'b0;
                if (seen != m_level[d][i]) begin
                    m_run[d][i]++;
                    if (m_run[d][i] == dcyc[d]) begin
                        m_level[d][i] = seen;
                        if (seen) m_press[d][i] = 1'b1;
                        else m_rel[d][i] = 1'b1;
                        m_run[d][i] = 0;
                    end
                end else begin
                    m_run[d][i] = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_d4", dut_out(0), model_out(0));
        check("model_d1", dut_out(1), model_out(1));
        for (int i = 0; i < NB; i++) begin
            pcnt[i] += int'(bus0.btn_press[i]);
            rcnt[i] += int'(bus0.btn_release[i]);
        end
    endtask

    initial begin
        logic [NB-1:0] p1, pm, r1, rm;
        int press_at, rel_at, np, nr;
        int hold[NB];
        logic [NB-1:0] el, ep;

        rows[0]  = '{4'b0001, 10, 4'b0001, 4'b0001, 4'b0000};
        rows[1]  = '{4'b1001, 10, 4'b1001, 4'b1000, 4'b0000};
        rows[2]  = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b1001};
        rows[3]  = '{4'b0010,  3, 4'b0000, 4'b0000, 4'b0000};
        rows[4]  = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b0000};
        rows[5]  = '{4'b0100,  4, 4'b0000, 4'b0000, 4'b0000};
        rows[6]  = '{4'b0000, 10, 4'b0000, 4'b0100, 4'b0100};
        rows[7]  = '{4'b1111,  8, 4'b1111, 4'b1111, 4'b0000};
        rows[8]  = '{4'b0101,  2, 4'b1111, 4'b0000, 4'b0000};
        rows[9]  = '{4'b1111, 10, 4'b1111, 4'b0000, 4'b0000};
        rows[10] = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b1111};

        model_reset();
        for (int i = 0; i < NB; i++) begin pcnt[i] = 0; rcnt[i] = 0; hold[i] = 0; end

        // Reset state
        raw = '0;
        rst = 1'b1;
        repeat (3) cycle();
        check("reset_state_d4", dut_out(0), 32'd0);
        check("reset_state_d1", dut_out(1), 32'd0);
        #2 rst = 1'b0;
        repeat (4) cycle();

        // Lane 0 latency: accepted on the 6th edge after the change (E+5)
        raw = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            check("latency_d4", dut_out(0),
                  32'({3'b000, 1'(k >= 6), 3'b000, 1'(k == 6), 4'b0000}));
            check("latency_d1", dut_out(1),
                  32'({3'b000, 1'(k >= 3), 3'b000, 1'(k == 3), 4'b0000}));
        end
        raw = '0;
        repeat (10) cycle();

        // Table-driven rows, pulses counted per row on the D=4 build
        foreach (rows[r]) begin
            for (int i = 0; i < NB; i++) begin pcnt[i] = 0; rcnt[i] = 0; end
            raw = rows[r].raw;
            repeat (rows[r].hold) cycle();
            for (int i = 0; i < NB; i++) begin
                p1[i] = (pcnt[i] == 1); pm[i] = (pcnt[i] > 1);
                r1[i] = (rcnt[i] == 1); rm[i] = (rcnt[i] > 1);
            end
            check($sformatf("row%0d_level", r), 32'(bus0.btn_level), 32'(rows[r].lvl));
            check($sformatf("row%0d_press", r), 32'({pm, p1}), 32'({4'b0000, rows[r].prs}));
            check($sformatf("row%0d_release", r), 32'({rm, r1}), 32'({4'b0000, rows[r].rel}));
        end

        // Lane 2 held 100 cycles: one press, one release, exactly 100 apart
        press_at = -1; rel_at = -1; np = 0; nr = 0;
        raw = 4'b0100;
        for (int c = 0; c < 140; c++) begin
            if (c == 100) raw = 4'b0000;
            cycle();
            if (bus0.btn_press[2]) begin np++; press_at = c; end
            if (bus0.btn_release[2]) begin nr++; rel_at = c; end
        end
        check("hold_press_count", 32'(np), 32'd1);
        check("hold_release_count", 32'(nr), 32'd1);
        check("hold_press_at", 32'(press_at), 32'd5);
        check("hold_pulse_gap", 32'(rel_at - press_at), 32'd100);

        // Async reset during a pending press while another lane is high
        raw = 4'b1000;
        repeat (10) cycle();
        raw = 4'b1001;
        repeat (4) cycle();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_d4", dut_out(0), 32'd0);
        check("async_reset_d1", dut_out(1), 32'd0);
        cycle();
        #2 rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            el = (k >= 6) ? 4'b1001 : 4'b0000;
            ep = (k == 6) ? 4'b1001 : 4'b0000;
            check("post_reset_d4", dut_out(0), 32'({el, ep, 4'b0000}));
        end

        // Randomised segments: short bounces mixed with long holds
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    raw[i] = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 12))
                                                           : int'($urandom_range(1, 4));
                end
                hold[i]--;
            end
            if ($urandom_range(0, 599) == 0) begin
                #1 rst = 1'b1;
                model_reset();
                cycle();
                #1 rst = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
